// File: rtl/alarm_scheduler_pkg.sv
// Shared definitions for the alarm scheduler: state codes and BCD digit limits.
package alarm_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t SET_H1 = 3'd1;
  localparam state_t SET_H2 = 3'd2;
  localparam state_t SET_M1 = 3'd3;
  localparam state_t SET_M2 = 3'd4;
  localparam state_t RING   = 3'd5;
  localparam state_t SNOOZE = 3'd6;

  localparam logic [3:0] HOUR1_MAX    = 4'd2;
  localparam logic [3:0] HOUR2_MAX_24 = 4'd3;
  localparam logic [3:0] MIN1_MAX     = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic is_set_state(input state_t s);
    return (s == SET_H1) || (s == SET_H2) || (s == SET_M1) || (s == SET_M2);
  endfunction

endpackage

// File: rtl/alarm_scheduler_bcd_digit_check.sv
// Combinational validity check for the digit currently being entered.
module bcd_digit_check
  import alarm_scheduler_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] data_in,
  input  logic [3:0] alm_hour1,
  output logic       valid
);

  // Apply the per-position limit; H2 depends on the already stored tens-of-hours digit.
  always_comb begin
    valid = 1'b0;
    case (state)
      SET_H1: valid = (data_in <= HOUR1_MAX);
      SET_H2: valid = (alm_hour1 < HOUR1_MAX) ? (data_in <= DIGIT_MAX)
                                               : (data_in <= HOUR2_MAX_24);
      SET_M1: valid = (data_in <= MIN1_MAX);
      SET_M2: valid = (data_in <= DIGIT_MAX);
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Wake-alarm controller: digit-by-digit alarm entry, time match, ring/snooze/timeout.
module alarm_scheduler
  import alarm_scheduler_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int CNT_W            = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_1s,
  input  logic [3:0] cur_hour1,
  input  logic [3:0] cur_hour2,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min2,
  input  logic [3:0] cur_sec1,
  input  logic [3:0] cur_sec2,
  input  logic       arm,
  input  logic       go,
  input  logic [3:0] data_in,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [3:0] alm_hour1,
  output logic [3:0] alm_hour2,
  output logic [3:0] alm_min1,
  output logic [3:0] alm_min2,
  output logic       setting,
  output logic       digit_err,
  output logic       ringing,
  output logic       snoozing,
  output logic       alarm_out
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             go_q, go_rise;
  logic             digit_ok, digit_wr, err_next, time_match;

  assign go_rise    = go & ~go_q;
  assign time_match = ({cur_hour1, cur_hour2, cur_min1, cur_min2} ==
                       {alm_hour1, alm_hour2, alm_min1, alm_min2}) &&
                      (cur_sec1 == 4'd0) && (cur_sec2 == 4'd0);

  assign setting  = is_set_state(state);
  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);

  bcd_digit_check u_check (
    .state     (state),
    .data_in   (data_in),
    .alm_hour1 (alm_hour1),
    .valid     (digit_ok)
  );

  // Next-state, counter and digit-write decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    digit_wr   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (go_rise) begin
          state_next = SET_H1;
        end else if (arm && tick_1s && time_match) begin
          state_next = RING;
          cnt_next   = '0;
        end
      end
      SET_H1, SET_H2, SET_M1, SET_M2: begin
        if (go_rise) begin
          if (digit_ok) begin
            digit_wr   = 1'b1;
            state_next = (state == SET_M2) ? IDLE : state_t'(state + 3'd1);
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RING: begin
        if (dismiss) begin
          state_next = IDLE;
        end else if (snooze) begin
          state_next = SNOOZE;
          cnt_next   = '0;
        end else if (!arm) begin
          state_next = IDLE;
        end else if (tick_1s) begin
          if (cnt == RING_LAST) state_next = IDLE;
          else                  cnt_next   = cnt + 1'b1;
        end
      end
      SNOOZE: begin
        if (dismiss || !arm) begin
          state_next = IDLE;
        end else if (tick_1s) begin
          if (cnt == SNOOZE_LAST) begin
            state_next = RING;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, edge detect and status pulse registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      go_q      <= 1'b0;
      digit_err <= 1'b0;
      alarm_out <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      go_q      <= go;
      digit_err <= err_next;
      // Registered from the next state so it tracks ringing cycle-for-cycle.
      alarm_out <= (state_next == RING);
    end
  end

  // Alarm time registers, written one digit per accepted entry.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      alm_hour1 <= '0;
      alm_hour2 <= '0;
      alm_min1  <= '0;
      alm_min2  <= '0;
    end else if (digit_wr) begin
      case (state)
        SET_H1: begin
          alm_hour1 <= data_in;
          if (data_in == HOUR1_MAX && alm_hour2 > HOUR2_MAX_24) alm_hour2 <= '0;
        end
        SET_H2:  alm_hour2 <= data_in;
        SET_M1:  alm_min1  <= data_in;
        SET_M2:  alm_min2  <= data_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler against a behavioural alarm-clock model.
module tb_alarm_scheduler;

  localparam int RING_T = 4;
  localparam int SNZ_T  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, tick_1s, arm, go, snooze, dismiss;
  logic [3:0] data_in, cur_hour1, cur_hour2, cur_min1, cur_min2, cur_sec1, cur_sec2;
  logic [3:0] alm_hour1, alm_hour2, alm_min1, alm_min2;
  logic       setting, digit_err, ringing, snoozing, alarm_out;

  alarm_scheduler #(
    .SNOOZE_SEC       (SNZ_T),
    .RING_TIMEOUT_SEC (RING_T),
    .CNT_W            (9)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tick_1s   (tick_1s),
    .cur_hour1 (cur_hour1),
    .cur_hour2 (cur_hour2),
    .cur_min1  (cur_min1),
    .cur_min2  (cur_min2),
    .cur_sec1  (cur_sec1),
    .cur_sec2  (cur_sec2),
    .arm       (arm),
    .go        (go),
    .data_in   (data_in),
    .snooze    (snooze),
    .dismiss   (dismiss),
    .alm_hour1 (alm_hour1),
    .alm_hour2 (alm_hour2),
    .alm_min1  (alm_min1),
    .alm_min2  (alm_min2),
    .setting   (setting),
    .digit_err (digit_err),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .alarm_out (alarm_out)
  );

  // Staged level inputs, applied at the next driven cycle.
  bit s_rst = 1'b1;
  bit s_arm = 1'b0;
  int s_time [6];

  // Reference model: alarm digits, entry position, seconds left ringing / snoozing.
  int m_alm [4];
  int m_idx     = -1;
  int m_ring    = 0;
  int m_snz     = 0;
  bit m_goprev  = 1'b0;
  bit m_err     = 1'b0;

  logic [20:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  function automatic bit digit_ok(input int idx, input int d);
    case (idx)
      0: return d <= 2;
      1: return (d <= 9) && (m_alm[0] * 10 + d <= 23);
      2: return d <= 5;
      default: return d <= 9;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit g,
                            input bit sz, input bit ds, input int d);
    bit rise;
    m_err = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_alm[i] = 0;
      m_idx = -1; m_ring = 0; m_snz = 0; m_goprev = 1'b0;
      return;
    end
    rise     = g && !m_goprev;
    m_goprev = g;
    if (m_ring > 0) begin
      if (ds)          m_ring = 0;
      else if (sz)     begin m_ring = 0; m_snz = SNZ_T; end
      else if (!s_arm) m_ring = 0;
      else if (tk)     m_ring = m_ring - 1;
    end else if (m_snz > 0) begin
      if (ds || !s_arm) m_snz = 0;
      else if (tk) begin
        m_snz = m_snz - 1;
        if (m_snz == 0) m_ring = RING_T;
      end
    end else if (m_idx >= 0) begin
      if (rise) begin
        if (digit_ok(m_idx, d)) begin
          m_alm[m_idx] = d;
          if (m_idx == 0 && d == 2 && m_alm[1] > 3) m_alm[1] = 0;
          m_idx = (m_idx == 3) ? -1 : m_idx + 1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      if (rise) m_idx = 0;
      else if (s_arm && tk && s_time[0] == m_alm[0] && s_time[1] == m_alm[1] &&
               s_time[2] == m_alm[2] && s_time[3] == m_alm[3] &&
               s_time[4] == 0 && s_time[5] == 0)
        m_ring = RING_T;
    end
  endtask

  function automatic logic [20:0] pack_exp();
    return {4'(m_alm[0]), 4'(m_alm[1]), 4'(m_alm[2]), 4'(m_alm[3]),
            m_idx >= 0, m_err, m_ring > 0, m_snz > 0, m_ring > 0};
  endfunction

  task automatic cyc(input bit tk, input bit g, input bit sz, input bit ds, input int d);
    @(negedge clk);
    resetn    = s_rst;
    arm       = s_arm;
    cur_hour1 = 4'(s_time[0]);
    cur_hour2 = 4'(s_time[1]);
    cur_min1  = 4'(s_time[2]);
    cur_min2  = 4'(s_time[3]);
    cur_sec1  = 4'(s_time[4]);
    cur_sec2  = 4'(s_time[5]);
    tick_1s   = tk;
    go        = g;
    snooze    = sz;
    dismiss   = ds;
    data_in   = 4'(d);
    model_step(s_rst, tk, g, sz, ds, d);
    exp_q.push_back(pack_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic enter(input int d);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, d);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic tick_at(input int h1, input int h2, input int m1, input int m2,
                         input int s1, input int s2);
    s_time[0] = h1; s_time[1] = h2; s_time[2] = m1;
    s_time[3] = m2; s_time[4] = s1; s_time[5] = s2;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expected output word per clock edge, popped just after the edge.
  initial begin
    logic [20:0] e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {alm_hour1, alm_hour2, alm_min1, alm_min2,
               setting, digit_err, ringing, snoozing, alarm_out};
        chk("outputs", 32'(act), 32'(e));
      end
    end
  end

  initial begin
    resetn = 1'b1; tick_1s = 1'b0; arm = 1'b0; go = 1'b0; snooze = 1'b0;
    dismiss = 1'b0; data_in = '0; cur_hour1 = '0; cur_hour2 = '0;
    cur_min1 = '0; cur_min2 = '0; cur_sec1 = '0; cur_sec2 = '0;
    for (int i = 0; i < 6; i++) s_time[i] = 0;

    s_rst = 1'b1; idle(3);
    s_rst = 1'b0; idle(2);

    // Entry of 07:30 and match at 07:30:00, then ring timeout.
    enter(0); enter(0); enter(7); enter(3); enter(0);
    s_arm = 1'b1;
    tick_at(0, 7, 2, 9, 5, 9);
    tick_at(0, 7, 3, 0, 0, 0);
    for (int i = 1; i <= RING_T; i++) tick_at(0, 7, 3, 0, 0, i);
    idle(2);

    // Digit rejection: 3 then 2 for H1, 5 then 3 for H2, minutes 00.
    enter(0); enter(3); enter(2); enter(5); enter(3); enter(0); enter(0);
    idle(1);

    // Snooze cycle, then dismiss+snooze together.
    tick_at(2, 3, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(1);
    for (int i = 1; i <= SNZ_T; i++) tick_at(2, 3, 0, 0, 0, i);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(1);

    // arm dropped while snoozing.
    tick_at(2, 3, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(1);
    s_arm = 1'b0; idle(2);
    s_arm = 1'b1;

    // H1 = 2 with a large H2 stored clears H2.
    enter(0); enter(1); enter(9); enter(5); enter(9);
    enter(0); enter(2); enter(1); enter(0); enter(0);

    // Asynchronous reset mid-ring, asserted at the falling edge.
    tick_at(2, 1, 0, 0, 0, 0);
    idle(1);
    s_rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("async_rst_alarm_out", 32'(alarm_out), 32'd0);
    chk("async_rst_ringing", 32'(ringing), 32'd0);
    chk("async_rst_alm", 32'({alm_hour1, alm_hour2, alm_min1, alm_min2}), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    s_rst = 1'b0; idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 499) == 0);
      s_arm = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 4; k++) s_time[k] = m_alm[k];
        s_time[4] = 0; s_time[5] = 0;
      end else begin
        s_time[0] = $urandom_range(0, 2);
        s_time[1] = $urandom_range(0, 9);
        s_time[2] = $urandom_range(0, 5);
        s_time[3] = $urandom_range(0, 9);
        s_time[4] = $urandom_range(0, 1);
        s_time[5] = $urandom_range(0, 1);
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15));
    end
    s_rst = 1'b0;
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Controller for the wake-alarm function of the clock design.
- Owns the programmed alarm time (HH:MM, BCD digits) and sequences its entry digit-by-digit from go pulses, with per-digit validity checks.
- Watches the running time supplied by the time datapath and fires the alarm at the matching HH:MM:00.
- Manages the ring/snooze/dismiss/auto-timeout lifecycle and drives alarm_out to the LED.

Parameters:
SNOOZE_SEC, 300, snooze duration in 1 s ticks
RING_TIMEOUT_SEC, 60, ring duration before auto-off, in 1 s ticks
CNT_W, 9, width of the shared tick counter; must hold max(SNOOZE_SEC, RING_TIMEOUT_SEC)

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  asynchronous, active-high reset
tick_1s  in  1  one-cycle pulse per second from the time datapath
cur_hour1, cur_hour2, cur_min1, cur_min2, cur_sec1, cur_sec2  in  4 each  current time, BCD
arm  in  1  level; alarm enabled when 1
go  in  1  level from a debounced key; a rising edge is detected internally
data_in  in  4  digit value being entered
snooze  in  1  one-cycle pulse
dismiss  in  1  one-cycle pulse
alm_hour1, alm_hour2, alm_min1, alm_min2  out  4 each  programmed alarm time, BCD
setting  out  1  high while in any SET state
digit_err  out  1  one-cycle pulse on a rejected digit
ringing  out  1  high in RING
snoozing  out  1  high in SNOOZE
alarm_out  out  1  registered; equals ringing

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; alm_* = 0 (alarm time 00:00); counter = 0; go edge register = 0; all other outputs 0.
- go edge: go_q <= go; go_rise = go & ~go_q. Only go_rise acts. Holding go does not repeat.
- States: IDLE, SET_H1, SET_H2, SET_M1, SET_M2, RING, SNOOZE. All outputs are registered or decoded from registered state.

IDLE
- go_rise -> SET_H1.
- Else, if arm & tick_1s & {cur_hour1..cur_min2} == {alm_*} & cur_sec1 == 0 & cur_sec2 == 0 -> RING, counter <= 0.
- ringing and alarm_out rise the cycle after the matching tick.

SET_x (x = H1, H2, M1, M2)
- On go_rise: if data_in is valid, write it to alm_x and advance H1 -> H2 -> M1 -> M2 -> IDLE.
- If data_in is invalid: digit_err pulses for one cycle, alm_x is unchanged, state is unchanged.
- Validity rules:
  - H1 <= 2.
  - H2 <= 9 if alm_hour1 < 2, else H2 <= 3.
  - M1 <= 5.
  - M2 <= 9.
- Entering H1 = 2 while alm_hour2 > 3 clears alm_hour2 to 0 in the same cycle.
- Alarm matching is suppressed in all SET states.

RING
- Priority: dismiss > snooze > arm low > timeout.
- dismiss -> IDLE.
- snooze -> SNOOZE, counter <= 0.
- arm = 0 -> IDLE.
- tick_1s: if counter == RING_TIMEOUT_SEC-1 -> IDLE, else counter + 1. alarm_out is therefore high for exactly RING_TIMEOUT_SEC ticks.
- go_rise is ignored.

SNOOZE
- dismiss or arm = 0 -> IDLE.
- tick_1s: if counter == SNOOZE_SEC-1 -> RING with counter <= 0, else counter + 1.
- A snooze pulse in SNOOZE is ignored.
- Snooze can repeat without limit.

Other rules
- A match tick arriving while in RING or SNOOZE has no effect.
- Counter arithmetic is unsigned CNT_W bits; it never wraps because it reloads at the terminal count.
- A simultaneous tick_1s and dismiss in RING resolves to IDLE.
- Reset mid-ring or mid-set returns to IDLE with alarm time 00:00.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE = 0, SET_H1 = 1, SET_H2 = 2, SET_M1 = 3, SET_M2 = 4, RING = 5, SNOOZE = 6, width 3);
  - BCD limit constants (HOUR1_MAX = 2, HOUR2_MAX_24 = 3, MIN1_MAX = 5, DIGIT_MAX = 9).
- One natural sub-module: bcd_digit_check, combinational; takes state, data_in and alm_hour1, outputs valid.
- The FSM, counter and alarm registers stay in alarm_scheduler.

Test Plan:
1. Entry and match:
   - Stimulus: reset; go edges entering 0,7,3,0; arm = 1; drive time 07:29:59, then a tick at 07:30:00.
   - Response: alm = 07:30; setting low after the 4th digit; alarm_out high the cycle after the tick.
2. Digit rejection:
   - Stimulus: in SET_H1 enter 3; then 2; then 5; then 3.
   - Response: digit_err pulse on 3 with alm_hour1 unchanged; 2 accepted; 5 rejected in SET_H2; 3 accepted; final hour = 23.
3. Auto-timeout (RING_TIMEOUT_SEC = 4):
   - Stimulus: trigger RING, apply 4 ticks.
   - Response: alarm_out high through the 4th tick, low the cycle after it; state IDLE.
4. Snooze (SNOOZE_SEC = 3):
   - Stimulus: in RING pulse snooze; apply 3 ticks.
   - Response: snoozing high, alarm_out low; RING re-entered after the 3rd tick with counter = 0.
5. Simultaneous events:
   - Stimulus: dismiss and snooze in the same cycle while ringing.
   - Response: IDLE.
   - Stimulus: arm = 0 while in SNOOZE.
   - Response: IDLE.
6. Async reset:
   - Stimulus: assert resetn mid-RING, between clock edges.
   - Response: alarm_out and ringing 0 immediately; alm_* = 0; state IDLE after release.
